// File: rtl/processor_pkg.sv
// Shared types and constants for the single-cycle core's control path.
package processor_pkg;

  localparam int PC_W_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } seq_state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_MOV   = 3'b001;
  localparam logic [2:0] OP_SHIFT = 3'b010;
  localparam logic [2:0] OP_LW    = 3'b011;
  localparam logic [2:0] OP_SW    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_BNE   = 3'b111;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: hold, branch target, skip (+2) or step (+1).
module pc_next_sel
  import processor_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            branch_skip,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] next_pc
);

  // Priority select; additions wrap silently modulo 2^PC_W.
  always_comb begin
    next_pc = pc;
    if (halt_req || stall) begin
      next_pc = pc;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (branch_skip) begin
      next_pc = pc + PC_W'(2);
    end else begin
      next_pc = pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run/halt sequencer with LW stall and halt acknowledge.
// Optional performance counters are enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer
  import processor_pkg::*;
#(
  parameter int          PC_W       = PC_W_DEF,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic [2:0]      opcode,
  input  logic            halt_req,
  input  logic            branch_taken,
  input  logic            branch_skip,
  input  logic [PC_W-1:0] branch_target,
  input  logic            mem_ready,
  output logic [PC_W-1:0] PC,
`ifdef PC_SEQ_PERF_EN
  output logic [15:0]     cycle_cnt,
  output logic [15:0]     instr_cnt,
`endif
  output logic            commit,
  output logic            Ack,
  output logic [1:0]      state
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  seq_state_t      state_r, state_nx_s;
  logic [PC_W-1:0] pc_r, pc_nx_s, sel_pc_s;
  logic            ack_r, ack_nx_s;
  logic            stall_s, run_s;

  assign stall_s = (opcode == OP_LW) && !mem_ready;
  assign run_s   = (state_r == S_RUN);

  pc_next_sel #(.PC_W(PC_W)) u_next_sel (
    .pc            (pc_r),
    .halt_req      (halt_req),
    .stall         (stall_s),
    .branch_taken  (branch_taken),
    .branch_skip   (branch_skip),
    .branch_target (branch_target),
    .next_pc       (sel_pc_s)
  );

  // Next-state and next-PC decode; Start overrides every RUN event.
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    case (state_r)
      S_IDLE: begin
        pc_nx_s = START_PC;
        if (Start) state_nx_s = S_IDLE;
        else       state_nx_s = S_RUN;
      end
      S_RUN: begin
        if (Start) begin
          state_nx_s = S_IDLE;
          pc_nx_s    = START_PC;
        end else if (halt_req) begin
          state_nx_s = S_HALT;
          pc_nx_s    = pc_r;
        end else begin
          state_nx_s = S_RUN;
          pc_nx_s    = sel_pc_s;
        end
      end
      S_HALT: begin
        if (Start) begin
          state_nx_s = S_IDLE;
          pc_nx_s    = START_PC;
        end else begin
          state_nx_s = S_HALT;
          pc_nx_s    = pc_r;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        pc_nx_s    = START_PC;
      end
    endcase
    ack_nx_s = (state_nx_s == S_HALT);
  end

  // State, PC and acknowledge registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r <= S_IDLE;
      pc_r    <= START_PC;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pc_r    <= pc_nx_s;
      ack_r   <= ack_nx_s;
    end
  end

  // Reset is folded in so the write gate drops without waiting for an edge.
  assign commit = run_s && !halt_req && !stall_s && !Reset;
  assign PC     = pc_r;
  assign Ack    = ack_r;
  assign state  = state_r;

`ifdef PC_SEQ_PERF_EN
  logic [15:0] cycle_cnt_r, instr_cnt_r;

  // The halting cycle is attributed to HALT, so it is not counted as a RUN cycle.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cycle_cnt_r <= 16'h0000;
      instr_cnt_r <= 16'h0000;
    end else if (Start) begin
      cycle_cnt_r <= 16'h0000;
      instr_cnt_r <= 16'h0000;
    end else begin
      if (run_s && !halt_req && (cycle_cnt_r != 16'hFFFF))
        cycle_cnt_r <= cycle_cnt_r + 16'h0001;
      else
        cycle_cnt_r <= cycle_cnt_r;
      if (commit && (instr_cnt_r != 16'hFFFF))
        instr_cnt_r <= instr_cnt_r + 16'h0001;
      else
        instr_cnt_r <= instr_cnt_r;
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer, plus hand-written reset and counter sequences.
module tb_pc_sequencer;

  logic       CLK = 1'b0;
  logic       Reset, Start, halt_req, branch_taken, branch_skip, mem_ready;
  logic [2:0] opcode;
  logic [9:0] branch_target;
  logic [9:0] PC;
  logic       commit, Ack;
  logic [1:0] state;
`ifdef PC_SEQ_PERF_EN
  logic [15:0] cycle_cnt, instr_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.PC_W(10), .START_ADDR(0)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .Start         (Start),
    .opcode        (opcode),
    .halt_req      (halt_req),
    .branch_taken  (branch_taken),
    .branch_skip   (branch_skip),
    .branch_target (branch_target),
    .mem_ready     (mem_ready),
    .PC            (PC),
`ifdef PC_SEQ_PERF_EN
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt),
`endif
    .commit        (commit),
    .Ack           (Ack),
    .state         (state)
  );

  typedef struct {
    logic       start;
    logic [2:0] op;
    logic       halt;
    logic       taken;
    logic       skip;
    logic       mr;
    logic [9:0] tgt;
    logic       exp_commit;
    logic [9:0] exp_pc;
    logic [1:0] exp_state;
    logic       exp_ack;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs[NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [2:0] op, input logic h, input logic t,
                              input logic k, input logic m, input logic [9:0] tg, input logic c,
                              input logic [9:0] p, input logic [1:0] st, input logic a);
    vec_t v;
    v.start = s; v.op = op; v.halt = h; v.taken = t; v.skip = k; v.mr = m; v.tgt = tg;
    v.exp_commit = c; v.exp_pc = p; v.exp_state = st; v.exp_ack = a;
    return v;
  endfunction

  task automatic drive(input logic s, input logic [2:0] op, input logic h, input logic t,
                       input logic k, input logic m, input logic [9:0] tg);
    Start = s; opcode = op; halt_req = h; branch_taken = t; branch_skip = k;
    mem_ready = m; branch_target = tg;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // start op halt taken skip mr tgt | commit(before edge) pc state ack (after edge)
    vecs[0]  = mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h000, 2'd0, 1'b0);
    vecs[1]  = mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h000, 2'd0, 1'b0);
    vecs[2]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h000, 2'd1, 1'b0);
    vecs[3]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 10'h001, 2'd1, 1'b0);
    vecs[4]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 10'h002, 2'd1, 1'b0);
    vecs[5]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 10'h003, 2'd1, 1'b0);
    vecs[6]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 10'h004, 2'd1, 1'b0);
    vecs[7]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 10'h005, 2'd1, 1'b0);
    vecs[8]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 1'b1, 10'h007, 2'd1, 1'b0);
    vecs[9]  = mk(1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 10'h020, 1'b1, 10'h020, 2'd1, 1'b0);
    // LW stall: flags ignored while stalled
    vecs[10] = mk(1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 10'h100, 1'b0, 10'h020, 2'd1, 1'b0);
    vecs[11] = mk(1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h020, 2'd1, 1'b0);
    vecs[12] = mk(1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 10'h021, 2'd1, 1'b0);
    // wrap cases
    vecs[13] = mk(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h3FF, 1'b1, 10'h3FF, 2'd1, 1'b0);
    vecs[14] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 10'h000, 2'd1, 1'b0);
    vecs[15] = mk(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h3FE, 1'b1, 10'h3FE, 2'd1, 1'b0);
    vecs[16] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 1'b1, 10'h000, 2'd1, 1'b0);
    vecs[17] = mk(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h00A, 1'b1, 10'h00A, 2'd1, 1'b0);
    // halt at 0x00A, hold 5 cycles, then Start
    vecs[18] = mk(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h00A, 2'd2, 1'b1);
    vecs[19] = mk(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h055, 1'b0, 10'h00A, 2'd2, 1'b1);
    vecs[20] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 1'b0, 10'h00A, 2'd2, 1'b1);
    vecs[21] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h00A, 2'd2, 1'b1);
    vecs[22] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h00A, 2'd2, 1'b1);
    vecs[23] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h00A, 2'd2, 1'b1);
    vecs[24] = mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h000, 2'd0, 1'b0);
    vecs[25] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h000, 2'd1, 1'b0);
    vecs[26] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 10'h001, 2'd1, 1'b0);
    // halt beats a simultaneous LW stall
    vecs[27] = mk(1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h001, 2'd2, 1'b1);
    vecs[28] = mk(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h000, 2'd0, 1'b0);
    vecs[29] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h000, 2'd1, 1'b0);
    vecs[30] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 10'h001, 2'd1, 1'b0);
    // Start in RUN overrides a taken branch
    vecs[31] = mk(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h055, 1'b1, 10'h000, 2'd0, 1'b0);

    Reset = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    tick();
    tick();
    check("reset_pc",     0, 32'(PC),     32'h0);
    check("reset_state",  0, 32'(state),  32'h0);
    check("reset_ack",    0, 32'(Ack),    32'h0);
    check("reset_commit", 0, 32'(commit), 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].op, vecs[i].halt, vecs[i].taken, vecs[i].skip,
            vecs[i].mr, vecs[i].tgt);
      #1;
      check("commit", i, 32'(commit), 32'(vecs[i].exp_commit));
      tick();
      check("pc",    i, 32'(PC),    32'(vecs[i].exp_pc));
      check("state", i, 32'(state), 32'(vecs[i].exp_state));
      check("ack",   i, 32'(Ack),   32'(vecs[i].exp_ack));
    end

    // Mid-run asynchronous reset at PC=0x013
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    tick();
    drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h013);
    tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    #1;
    check("pre_rst_pc",     0, 32'(PC),     32'h013);
    check("pre_rst_commit", 0, 32'(commit), 32'h1);
    #1;
    Reset = 1'b1;
    #1;
    check("async_rst_pc",     0, 32'(PC),     32'h000);
    check("async_rst_state",  0, 32'(state),  32'h0);
    check("async_rst_commit", 0, 32'(commit), 32'h0);
    tick();
    Reset = 1'b0;

`ifdef PC_SEQ_PERF_EN
    // ADD, LW (2 stall cycles), SW, then halt: 5 RUN cycles, 3 commits
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    tick();
    check("perf_clear_cyc", 0, 32'(cycle_cnt), 32'h0);
    check("perf_clear_ins", 0, 32'(instr_cnt), 32'h0);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    tick();
    tick();
    drive(1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    tick();
    tick();
    drive(1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    tick();
    drive(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    tick();
    drive(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
    tick();
    check("perf_halt_state", 0, 32'(state),     32'h2);
    check("perf_cycle_cnt",  0, 32'(cycle_cnt), 32'd5);
    check("perf_instr_cnt",  0, 32'(instr_cnt), 32'd3);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    tick();
    tick();
    check("perf_frozen_cyc", 0, 32'(cycle_cnt), 32'd5);
    check("perf_frozen_ins", 0, 32'(instr_cnt), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-sequencing controller for the single-cycle core.
- Owns the program counter and run/halt state, and consumes the ALU branch flags (taken / skip) and the halt condition.
- Stalls commit while a load waits on data memory, and raises Ack to the testbench/top level when the program halts.
- Sits between the ALU/decode outputs and the instruction ROM address; gates register-file and data-memory writes.

Parameters:
- PC_W, 10, program counter width; instruction ROM depth 2^PC_W.
- START_ADDR, 0, PC value loaded on reset and on Start.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  level request: while high, hold in IDLE with PC=START_ADDR.
- opcode  input  3  current instruction opcode (3'b011 = LW).
- halt_req  input  1  decode flags halt: shift opcode 3'b010 with operand B == 0.
- branch_taken  input  1  from ALU: load branch_target.
- branch_skip  input  1  from ALU: skip the next instruction.
- branch_target  input  PC_W  absolute target from the branch LUT.
- mem_ready  input  1  data memory has load data valid this cycle.
- PC  output  PC_W  registered instruction address.
- commit  output  1  combinational write-enable gate for regfile/data memory.
- Ack  output  1  registered; high while in HALT.
- state  output  2  current FSM state, for debug.

Behaviour:
- Reset (async, any time, including mid-run):
  - state=IDLE, PC=START_ADDR, Ack=0.
  - commit=0 immediately.
- FSM states: IDLE=2'd0, RUN=2'd1, HALT=2'd2; 2'd3 is illegal and goes to IDLE next edge.
- Start=1 in any state: next state IDLE, PC<=START_ADDR, Ack<=0. Start has priority over all RUN events.
- IDLE with Start=0: next state RUN. PC stays START_ADDR, so the first instruction executes in the first RUN cycle.
- RUN next-PC priority, evaluated each cycle (highest first):
  1. halt_req=1: PC holds, state<=HALT, Ack<=1 next edge, commit=0 this cycle.
  2. stall = (opcode==3'b011 && !mem_ready): PC holds, commit=0, state stays RUN.
  3. branch_taken=1: PC<=branch_target. Taken wins if skip is also asserted.
  4. branch_skip=1: PC<=PC+2.
  5. otherwise: PC<=PC+1.
- commit=1 only in RUN with no halt_req and no stall. It is 0 in IDLE and HALT.
- PC arithmetic is modulo 2^PC_W: PC+1 at all-ones wraps to 0, and PC+2 wraps likewise. Wrap is silent, with no halt or error.
- LW stall has no timeout. Branch flags are ignored during a stall cycle and re-evaluated once mem_ready rises.
- HALT: PC and Ack hold, commit=0. Only Start or Reset leaves HALT.
- Latency:
  - PC update: 1 cycle after the flags are sampled.
  - Ack: rises 1 cycle after the halt_req edge is sampled.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- When defined, two extra outputs are added:
  - cycle_cnt[15:0]: increments every RUN cycle.
  - instr_cnt[15:0]: increments on each commit=1 cycle.
- Both counters clear on Reset and on Start, freeze in HALT, and saturate at 16'hFFFF.
- When undefined: ports absent, no counter logic, behaviour otherwise identical.

Decomposition:
- Shared package processor_pkg holds:
  - the seq_state_t enum (IDLE/RUN/HALT);
  - opcode constants OP_ADD, OP_MOV, OP_SHIFT, OP_LW, OP_SW, OP_XOR, OP_AND, OP_BNE;
  - PC_W default.
- One combinational sub-module, pc_next_sel. It takes PC, the flags, stall and target, and produces next_pc. The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset asserted mid-RUN at PC=0x013 -> PC=0x000, state=IDLE, commit=0 in the same cycle (no clock edge needed).
- Start high 2 cycles then low; plain ADD opcodes -> PC stays 0 in IDLE, then 0,1,2,3 on successive RUN cycles with commit=1.
- At PC=5: branch_skip=1 -> PC=7. At PC=7: branch_taken=1 and branch_skip=1 with target=0x020 -> PC=0x020.
- opcode=LW with mem_ready low 2 cycles, then high -> PC holds for 2 cycles with commit=0, then advances by 1 with commit=1.
- PC=0x3FF with no flags -> PC=0x000. PC=0x3FE with branch_skip -> PC=0x000.
- halt_req at PC=0x00A -> Ack=1 next cycle; PC stays 0x00A and commit=0 for 5 cycles; Start pulse -> Ack=0, PC=0.
- Optional feature: with PC_SEQ_PERF_EN, a 3-instruction program plus 2 stall cycles gives cycle_cnt=5 and instr_cnt=3 at HALT.
